// File: rtl/alu_pkg.sv
// alu_pkg: constants and types shared by the ALU command sequencer and its bench.
//   - opcode constants for the external ALU (1..16 are defined, anything else is
//     passed through untouched by the sequencer)
//   - bit positions inside the 5-bit status word {carry, zero, eq, lt, gt}
//   - FSM state encoding of the sequencer
//   - the packed command record stored in the FIFO, plus a packing helper
package alu_pkg;

  localparam int OP_W   = 5;
  localparam int DATA_W = 8;
  localparam int TAG_W  = 4;
  localparam int STAT_W = 5;

  // ALU opcodes
  localparam logic [OP_W-1:0] OP_ADD   = 5'd1;
  localparam logic [OP_W-1:0] OP_SUB   = 5'd2;
  localparam logic [OP_W-1:0] OP_AND   = 5'd3;
  localparam logic [OP_W-1:0] OP_OR    = 5'd4;
  localparam logic [OP_W-1:0] OP_XOR   = 5'd5;
  localparam logic [OP_W-1:0] OP_NOT   = 5'd6;
  localparam logic [OP_W-1:0] OP_SLL   = 5'd7;
  localparam logic [OP_W-1:0] OP_SRL   = 5'd8;
  localparam logic [OP_W-1:0] OP_RLL   = 5'd9;
  localparam logic [OP_W-1:0] OP_RRL   = 5'd10;
  localparam logic [OP_W-1:0] OP_CPSEQ = 5'd11;
  localparam logic [OP_W-1:0] OP_CPSLT = 5'd12;
  localparam logic [OP_W-1:0] OP_CPSGT = 5'd13;
  localparam logic [OP_W-1:0] OP_INC   = 5'd14;
  localparam logic [OP_W-1:0] OP_DEC   = 5'd15;
  localparam logic [OP_W-1:0] OP_PASS  = 5'd16;

  // Status bit positions
  localparam int ST_CARRY = 4;
  localparam int ST_ZERO  = 3;
  localparam int ST_EQ    = 2;
  localparam int ST_LT    = 1;
  localparam int ST_GT    = 0;

  // Sequencer FSM encoding
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] in1;
    logic [DATA_W-1:0] in2;
  } cmd_t;

  localparam int CMD_W = $bits(cmd_t);

  function automatic cmd_t pack_cmd(input logic [TAG_W-1:0]  tag,
                                    input logic [OP_W-1:0]   op,
                                    input logic [DATA_W-1:0] in1,
                                    input logic [DATA_W-1:0] in2);
    cmd_t c;
    c.tag = tag;
    c.op  = op;
    c.in1 = in1;
    c.in2 = in2;
    return c;
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// alu_cmd_fifo: synchronous FIFO holding queued ALU commands.
// Ports:
//   clk, reset_n   clock / asynchronous active-low reset (flushes the FIFO)
//   push, din      write din when push=1 and not full
//   pop, dout      dout is the head entry; pop=1 and not empty advances it
//   full, empty    derived from the registered occupancy count only
// DEPTH must be a power of two so the pointers wrap naturally.
module alu_cmd_fifo #(
  parameter int WIDTH = 25,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  // Guard the strobes so an overflow/underflow request is simply ignored
  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;
  assign full   = (r_count == FULL_CNT);
  assign empty  = (r_count == '0);
  assign dout   = r_mem[r_rd_ptr];

  // Storage array: contents need no reset, the pointers define validity
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/alu_cmd_seq.sv
// alu_cmd_seq: queues ALU commands and sequences them one at a time through an
// external registered ALU, returning one tagged response per command.
// Ports:
//   clk, reset_n                    clock / asynchronous active-low reset
//   cmd_valid/cmd_ready             command handshake; cmd_op, cmd_in1, cmd_in2, cmd_tag
//   alu_enable, alu_in1/2, alu_op   request to the ALU (held stable while waiting)
//   alu_out, alu_status, alu_ready  ALU result, flags and result-valid strobe
//   rsp_valid/rsp_ready             response handshake; rsp_data, rsp_status, rsp_tag,
//                                   rsp_err (1 = the ALU never answered, result zeroed)
//   busy                            a command is in flight or queued
// Flow: IDLE pops the FIFO head -> ISSUE (one cycle) -> WAIT for alu_ready or the
// timeout -> RESP holds the response until it is accepted.
module alu_cmd_seq
  import alu_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [OP_W-1:0]   cmd_op,
  input  logic [DATA_W-1:0] cmd_in1,
  input  logic [DATA_W-1:0] cmd_in2,
  input  logic [TAG_W-1:0]  cmd_tag,
  output logic              alu_enable,
  output logic [DATA_W-1:0] alu_in1,
  output logic [DATA_W-1:0] alu_in2,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [STAT_W-1:0] alu_status,
  input  logic              alu_ready,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [STAT_W-1:0] rsp_status,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic              rsp_err,
  output logic              busy
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]        r_state;
  logic [1:0]        w_next_state;
  logic              r_rdy_en;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_alu_enable;
  logic [OP_W-1:0]   r_op;
  logic [DATA_W-1:0] r_in1;
  logic [DATA_W-1:0] r_in2;
  logic [TAG_W-1:0]  r_tag;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_data;
  logic [STAT_W-1:0] r_rsp_status;
  logic              r_rsp_err;

  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  cmd_t              w_din;
  cmd_t              w_head;

  // cmd_ready comes only from registers: r_rdy_en keeps it low for the first
  // cycle after reset release, and a same-cycle pop never frees a full FIFO.
  assign cmd_ready  = r_rdy_en & ~w_full;
  assign w_push     = cmd_valid & cmd_ready;
  assign w_din      = pack_cmd(cmd_tag, cmd_op, cmd_in1, cmd_in2);
  assign busy       = (r_state != S_IDLE) | ~w_empty;

  assign alu_enable = r_alu_enable;
  assign alu_in1    = r_in1;
  assign alu_in2    = r_in2;
  assign alu_op     = r_op;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_data   = r_rsp_data;
  assign rsp_status = r_rsp_status;
  assign rsp_tag    = r_tag;
  assign rsp_err    = r_rsp_err;

  alu_cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (w_push),
    .pop     (w_pop),
    .din     (w_din),
    .dout    (w_head),
    .full    (w_full),
    .empty   (w_empty)
  );

  // Next-state decode and FIFO pop strobe
  always_comb begin
    w_next_state = r_state;
    w_pop        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_next_state = S_ISSUE;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_ISSUE: w_next_state = S_WAIT;
      S_WAIT: begin
        // a result arriving in the last timeout cycle still wins
        if (alu_ready || (r_cnt == CNT_LAST)) begin
          w_next_state = S_RESP;
        end else begin
          w_next_state = S_WAIT;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          w_next_state = S_IDLE;
        end else begin
          w_next_state = S_RESP;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // State, operand, timeout and response registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_rdy_en     <= 1'b0;
      r_cnt        <= '0;
      r_alu_enable <= 1'b0;
      r_op         <= '0;
      r_in1        <= '0;
      r_in2        <= '0;
      r_tag        <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_data   <= '0;
      r_rsp_status <= '0;
      r_rsp_err    <= 1'b0;
    end else begin
      r_state  <= w_next_state;
      r_rdy_en <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (!w_empty) begin
            r_op         <= w_head.op;
            r_in1        <= w_head.in1;
            r_in2        <= w_head.in2;
            r_tag        <= w_head.tag;
            r_alu_enable <= 1'b1;
          end
        end
        S_ISSUE: r_cnt <= '0;
        S_WAIT: begin
          if (alu_ready) begin
            r_rsp_data   <= alu_out;
            r_rsp_status <= alu_status;
            r_rsp_err    <= 1'b0;
            r_rsp_valid  <= 1'b1;
            r_alu_enable <= 1'b0;
          end else if (r_cnt == CNT_LAST) begin
            r_rsp_data   <= '0;
            r_rsp_status <= '0;
            r_rsp_err    <= 1'b1;
            r_rsp_valid  <= 1'b1;
            r_alu_enable <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
          end
        end
        default: r_alu_enable <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_seq.sv
// tb_alu_cmd_seq: directed bench for alu_cmd_seq with a behavioural registered
// ALU (programmable answer latency) and a response scoreboard.
module tb_alu_cmd_seq;
  import alu_pkg::*;

  localparam int DEPTH = 4;
  localparam int TMO   = 8;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [OP_W-1:0]   cmd_op = '0;
  logic [DATA_W-1:0] cmd_in1 = '0;
  logic [DATA_W-1:0] cmd_in2 = '0;
  logic [TAG_W-1:0]  cmd_tag = '0;
  logic              alu_enable;
  logic [DATA_W-1:0] alu_in1;
  logic [DATA_W-1:0] alu_in2;
  logic [OP_W-1:0]   alu_op;
  logic [DATA_W-1:0] alu_out;
  logic [STAT_W-1:0] alu_status;
  logic              alu_ready;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [DATA_W-1:0] rsp_data;
  logic [STAT_W-1:0] rsp_status;
  logic [TAG_W-1:0]  rsp_tag;
  logic              rsp_err;
  logic              busy;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
    logic [STAT_W-1:0] status;
    logic              err;
  } rsp_t;

  rsp_t sb[$];
  int   n_checks  = 0;
  int   n_fail    = 0;
  int   alu_lat   = 0;
  int   en_cnt    = 0;
  int   rsp_count = 0;

  always #5 clk = ~clk;

  alu_cmd_seq #(
    .FIFO_DEPTH (DEPTH),
    .TIMEOUT    (TMO)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_in1    (cmd_in1),
    .cmd_in2    (cmd_in2),
    .cmd_tag    (cmd_tag),
    .alu_enable (alu_enable),
    .alu_in1    (alu_in1),
    .alu_in2    (alu_in2),
    .alu_op     (alu_op),
    .alu_out    (alu_out),
    .alu_status (alu_status),
    .alu_ready  (alu_ready),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_status (rsp_status),
    .rsp_tag    (rsp_tag),
    .rsp_err    (rsp_err),
    .busy       (busy)
  );

  // Reference ALU: returns {status, data}
  function automatic logic [12:0] alu_model(input logic [4:0] op, input logic [7:0] a,
                                            input logic [7:0] b);
    logic [8:0] s;
    logic [7:0] d;
    logic [4:0] st;
    d  = 8'd0;
    st = 5'd0;
    case (op)
      OP_ADD: begin
        s = {1'b0, a} + {1'b0, b};
        d = s[7:0];
        st[ST_CARRY] = s[8];
        st[ST_ZERO]  = (d == 8'd0);
      end
      OP_SUB: begin
        s = {1'b0, a} - {1'b0, b};
        d = s[7:0];
        st[ST_CARRY] = s[8];
        st[ST_ZERO]  = (d == 8'd0);
      end
      OP_RLL: begin
        d = a;
        for (int i = 0; i < int'(b[2:0]); i++) d = {d[6:0], d[7]};
        st[ST_ZERO] = (d == 8'd0);
      end
      OP_CPSEQ, OP_CPSLT, OP_CPSGT: begin
        st[ST_EQ] = (a == b);
        st[ST_LT] = (a < b);
        st[ST_GT] = (a > b);
      end
      default: begin
        d  = 8'd0;
        st = 5'd0;
      end
    endcase
    return {st, d};
  endfunction

  // Behavioural ALU: answers alu_lat cycles after alu_enable first rises
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      alu_ready  <= 1'b0;
      alu_out    <= 8'd0;
      alu_status <= 5'd0;
      en_cnt     <= 0;
    end else if (alu_enable) begin
      en_cnt <= en_cnt + 1;
      if (en_cnt == alu_lat) begin
        {alu_status, alu_out} <= alu_model(alu_op, alu_in1, alu_in2);
        alu_ready <= 1'b1;
      end else begin
        alu_ready <= 1'b0;
      end
    end else begin
      en_cnt    <= 0;
      alu_ready <= 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
    end
  endtask

  // Scoreboard: push on command acceptance, pop/compare on response handshake
  always @(negedge clk) begin
    rsp_t        e;
    logic [12:0] r;
    if (!reset_n) begin
      sb.delete();
    end else begin
      if (cmd_valid && cmd_ready) begin
        r     = alu_model(cmd_op, cmd_in1, cmd_in2);
        e.tag = cmd_tag;
        e.err = (alu_lat >= TMO);
        e.data   = e.err ? 8'd0 : r[7:0];
        e.status = e.err ? 5'd0 : r[12:8];
        sb.push_back(e);
      end
      if (rsp_valid && rsp_ready) begin
        rsp_count++;
        check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("rsp_tag",    32'(rsp_tag),    32'(e.tag));
          check("rsp_data",   32'(rsp_data),   32'(e.data));
          check("rsp_status", 32'(rsp_status), 32'(e.status));
          check("rsp_err",    32'(rsp_err),    32'(e.err));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a command, wait for cmd_ready, return just after the accepting edge
  task automatic send(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic [3:0] tag);
    int n;
    cmd_op    = op;
    cmd_in1   = a;
    cmd_in2   = b;
    cmd_tag   = tag;
    cmd_valid = 1'b1;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    check("send_bound", 32'(n < 100), 32'd1);
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((sb.size() != 0 || busy !== 1'b0) && n < 300) begin
      step();
      n++;
    end
    check("drain_bound", 32'(n < 300), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rc;
    // reset state
    #2;
    check("rst_cmd_ready",  32'(cmd_ready),  32'd0);
    check("rst_alu_enable", 32'(alu_enable), 32'd0);
    check("rst_alu_in1",    32'(alu_in1),    32'd0);
    check("rst_alu_op",     32'(alu_op),     32'd0);
    check("rst_rsp_valid",  32'(rsp_valid),  32'd0);
    check("rst_rsp_tag",    32'(rsp_tag),    32'd0);
    check("rst_rsp_err",    32'(rsp_err),    32'd0);
    check("rst_busy",       32'(busy),       32'd0);
    step();
    step();
    reset_n = 1'b1;
    check("rel_cmd_ready_lo", 32'(cmd_ready), 32'd0);
    step();
    check("rel_cmd_ready_hi", 32'(cmd_ready), 32'd1);

    // single add with latency
    rsp_ready = 1'b1;
    send(OP_ADD, 8'd200, 8'd100, 4'd3);
    step();
    check("add_issue_en", 32'(alu_enable), 32'd1);
    check("add_issue_op", 32'(alu_op),     32'd1);
    check("add_busy",     32'(busy),       32'd1);
    step();
    check("add_t2_valid", 32'(rsp_valid),  32'd0);
    check("add_wait_in1", 32'(alu_in1),    32'd200);
    step();
    check("add_t3_valid",  32'(rsp_valid),  32'd1);
    check("add_data",      32'(rsp_data),   32'd44);
    check("add_status",    32'(rsp_status), 32'h10);
    check("add_tag",       32'(rsp_tag),    32'd3);
    check("add_err",       32'(rsp_err),    32'd0);
    check("add_resp_en",   32'(alu_enable), 32'd0);
    step();
    check("add_done_valid", 32'(rsp_valid), 32'd0);
    check("add_idle_busy",  32'(busy),      32'd0);
    check("add_hold_in2",   32'(alu_in2),   32'd100);

    // back-pressure, then push rejected during pop at full
    rc = rsp_count;
    rsp_ready = 1'b0;
    for (int k = 1; k <= 5; k++) send(OP_ADD, 8'(k * 10), 8'(k), 4'(k));
    check("bp_full_ready",  32'(cmd_ready), 32'd0);
    check("bp_resp_valid",  32'(rsp_valid), 32'd1);
    check("bp_resp_tag",    32'(rsp_tag),   32'd1);
    cmd_op = OP_SUB; cmd_in1 = 8'd60; cmd_in2 = 8'd6; cmd_tag = 4'd6; cmd_valid = 1'b1;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check("bp_after_rsp_ready", 32'(cmd_ready), 32'd0);
    step();
    check("bp_pop_frees_one", 32'(cmd_ready), 32'd1);
    step();
    cmd_valid = 1'b0;
    check("bp_refull_ready", 32'(cmd_ready), 32'd0);
    rsp_ready = 1'b1;
    wait_idle();
    check("bp_rsp_count", 32'(rsp_count - rc), 32'd6);

    // timeout, then timeout-cycle priority, then normal recovery
    alu_lat = 20;
    send(OP_ADD, 8'd1, 8'd2, 4'd5);
    for (int i = 0; i < 9; i++) step();
    check("tmo_t9_valid", 32'(rsp_valid),  32'd0);
    check("tmo_t9_en",    32'(alu_enable), 32'd1);
    step();
    check("tmo_valid",  32'(rsp_valid),  32'd1);
    check("tmo_err",    32'(rsp_err),    32'd1);
    check("tmo_data",   32'(rsp_data),   32'd0);
    check("tmo_status", 32'(rsp_status), 32'd0);
    wait_idle();
    alu_lat = 7;
    send(OP_ADD, 8'd7, 8'd9, 4'd6);
    for (int i = 0; i < 9; i++) step();
    check("prio_t9_valid", 32'(rsp_valid), 32'd0);
    step();
    check("prio_valid", 32'(rsp_valid), 32'd1);
    check("prio_err",   32'(rsp_err),   32'd0);
    check("prio_data",  32'(rsp_data),  32'd16);
    wait_idle();
    alu_lat = 0;
    send(OP_SUB, 8'd9, 8'd4, 4'd7);
    wait_idle();

    // compare, rotate, invalid opcode
    send(OP_CPSEQ, 8'd5, 8'd5, 4'd8);
    send(OP_RLL, 8'h81, 8'd1, 4'd9);
    wait_idle();
    send(5'b11111, 8'd12, 8'd34, 4'd10);
    step();
    check("inv_issue_op", 32'(alu_op), 32'h1f);
    wait_idle();

    // reset while a command waits and two are queued
    alu_lat = 20;
    send(OP_ADD, 8'd1, 8'd1, 4'd11);
    send(OP_ADD, 8'd2, 8'd2, 4'd12);
    send(OP_ADD, 8'd3, 8'd3, 4'd13);
    step();
    check("mid_wait_en", 32'(alu_enable), 32'd1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(rsp_valid), 32'd0);
    check("mid_rst_busy",  32'(busy),      32'd0);
    step();
    reset_n = 1'b1;
    alu_lat = 0;
    step();
    check("mid_rel_ready", 32'(cmd_ready), 32'd1);
    check("mid_rel_busy",  32'(busy),      32'd0);
    rc = rsp_count;
    for (int i = 0; i < 15; i++) step();
    check("mid_no_rsp",    32'(rsp_count - rc), 32'd0);
    check("mid_still_idle", 32'(busy), 32'd0);
    send(OP_ADD, 8'd3, 8'd4, 4'd14);
    wait_idle();
    check("final_rsp_count", 32'(rsp_count - rc), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
